// File: rtl/mmio_input_port_pkg.sv
// Shared constants and register decode for the MMIO input port.
// Register offsets, bus widths and the word-index decoder.
package mmio_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] OFF_STATE = 4'h0;
    localparam logic [ADDR_W-1:0] OFF_EVENT = 4'h4;
    localparam logic [ADDR_W-1:0] OFF_IRQEN = 4'h8;

    typedef enum logic [1:0] {
        REG_STATE,
        REG_EVENT,
        REG_IRQEN,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode(input logic [1:0] word);
        reg_sel_e sel;
        sel = REG_NONE;
        if (word == OFF_STATE[3:2])
            sel = REG_STATE;
        else if (word == OFF_EVENT[3:2])
            sel = REG_EVENT;
        else if (word == OFF_IRQEN[3:2])
            sel = REG_IRQEN;
        return sel;
    endfunction

endpackage

// File: rtl/mmio_input_port_if.sv
// Load/store port between the core and the MMIO input peripheral.
// Single-cycle strobes, read data returned one clock later.
interface mmio_bus_if
    import mmio_pkg::*;
    ();

    logic [ADDR_W-1:0] bus_addr;
    logic              bus_rd;
    logic              bus_wr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;

    modport master (
        output bus_addr,
        output bus_rd,
        output bus_wr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_rvalid
    );

    modport slave (
        input  bus_addr,
        input  bus_rd,
        input  bus_wr,
        input  bus_wdata,
        output bus_rdata,
        output bus_rvalid
    );

endinterface

// File: rtl/mmio_input_port_debounce.sv
// One input bit: 2-flop synchroniser, stability counter, accepted level
// and a pulse on the cycle a new high level is accepted.
module debounce_cell #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_accept;

    assign w_differ = r_sync2 != r_stable;
    assign w_accept = w_differ && (r_cnt == CNT_W'(DEB_CYCLES - 1));
    assign o_stable = r_stable;
    assign o_rise   = w_accept && r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped input port: debounced STATE, sticky W1C EVENT,
// IRQ_EN mask and a registered level interrupt.
module mmio_input_port
    import mmio_pkg::*;
#(
    parameter int NUM_IN     = 10,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IN-1:0] raw_in,
    mmio_bus_if.slave         bus,
    output logic              irq
);

    logic [NUM_IN-1:0] w_stable;
    logic [NUM_IN-1:0] w_rise;
    logic [NUM_IN-1:0] r_event;
    logic [NUM_IN-1:0] r_irq_en;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_irq;

    reg_sel_e          w_sel;
    logic [NUM_IN-1:0] w_clr;
    logic [NUM_IN-1:0] w_event_nxt;
    logic [NUM_IN-1:0] w_irq_en_nxt;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cell
        debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_raw    (raw_in[gi]),
            .o_stable (w_stable[gi]),
            .o_rise   (w_rise[gi])
        );
    end

    assign w_unused = ^{bus.bus_addr[1:0], bus.bus_wdata};

    // Read mux samples pre-write values; a new rise beats a same-cycle clear.
    always_comb begin
        w_sel        = decode(bus.bus_addr[3:2]);
        w_clr        = '0;
        w_irq_en_nxt = r_irq_en;
        w_rd_data    = '0;
        if (bus.bus_wr && w_sel == REG_EVENT)
            w_clr = bus.bus_wdata[NUM_IN-1:0];
        if (bus.bus_wr && w_sel == REG_IRQEN)
            w_irq_en_nxt = bus.bus_wdata[NUM_IN-1:0];
        w_event_nxt = (r_event & ~w_clr) | w_rise;
        case (w_sel)
            REG_STATE: w_rd_data[NUM_IN-1:0] = w_stable;
            REG_EVENT: w_rd_data[NUM_IN-1:0] = r_event;
            REG_IRQEN: w_rd_data[NUM_IN-1:0] = r_irq_en;
            default:   w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_event  <= '0;
            r_irq_en <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_event  <= w_event_nxt;
            r_irq_en <= w_irq_en_nxt;
            r_rvalid <= bus.bus_rd;
            if (bus.bus_rd)
                r_rdata <= w_rd_data;
            r_irq <= |(w_event_nxt & w_irq_en_nxt);
        end
    end

    assign bus.bus_rdata  = r_rdata;
    assign bus.bus_rvalid = r_rvalid;
    assign irq            = r_irq;

endmodule

// File: tb/tb_mmio_input_port.sv
// Directed bench for mmio_input_port with DEB_CYCLES=4, NUM_IN=10.
module tb_mmio_input_port;
    import mmio_pkg::*;

    localparam int NUM_IN = 10;
    localparam int DEB    = 4;
    localparam int CW     = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_IN-1:0] raw_in = '0;
    logic              irq;
    int                checks = 0;
    int                errors = 0;

    mmio_bus_if bus ();

    mmio_input_port #(
        .NUM_IN     (NUM_IN),
        .DEB_CYCLES (DEB),
        .CNT_W      (CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_in  (raw_in),
        .bus     (bus.slave),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d,
                            output logic v);
        bus.bus_addr = a;
        bus.bus_rd   = 1'b1;
        tick(1);
        bus.bus_rd = 1'b0;
        d = bus.bus_rdata;
        v = bus.bus_rvalid;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] w);
        bus.bus_addr  = a;
        bus.bus_wdata = w;
        bus.bus_wr    = 1'b1;
        tick(1);
        bus.bus_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        logic [3:0]  addrs [3];
        addrs = '{4'h0, 4'h4, 4'h8};
        reset_n = 1'b0;
        tick(3);
        checks++;
        if (irq !== 1'b0 || bus.bus_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs irq=%b rvalid=%b want 0 0",
                     irq, bus.bus_rvalid);
        end
        reset_n = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            bus_read(addrs[i], d, v);
            checks++;
            if (d !== 32'h0 || v !== 1'b1) begin
                errors++;
                $display("FAIL reset_read a=%h got %h/%b want 0/1",
                         addrs[i], d, v);
            end
            tick(1);
            checks++;
            if (bus.bus_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rvalid_pulse got %b want 0", bus.bus_rvalid);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
    endtask

    task automatic test_rise();
        logic [31:0] d;
        logic        v;
        raw_in[3] = 1'b1;
        tick(5);
        bus_read(4'h0, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL state_early got %h want %h", d, 32'h0);
        end
        bus_read(4'h0, d, v);
        checks++;
        if (d !== 32'h8 || v !== 1'b1) begin
            errors++;
            $display("FAIL state_rise got %h/%b want %h/1", d, v, 32'h8);
        end
        tick(1);
        checks++;
        if (bus.bus_rdata !== 32'h8 || bus.bus_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rdata_hold got %h/%b want %h/0",
                     bus.bus_rdata, bus.bus_rvalid, 32'h8);
        end
        bus_read(4'h4, d, v);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("FAIL event_rise got %h want %h", d, 32'h8);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked got %b want 0", irq);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic        v;
        raw_in[0] = 1'b1;
        tick(3);
        raw_in[0] = 1'b0;
        tick(8);
        bus_read(4'h0, d, v);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("FAIL glitch_state got %h want %h", d, 32'h8);
        end
        bus_read(4'h4, d, v);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("FAIL glitch_event got %h want %h", d, 32'h8);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic        v;
        bus_write(4'h4, 32'h8);
        bus_read(4'h4, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL w1c_clear got %h want %h", d, 32'h0);
        end
        bus_write(4'h8, 32'h3FF);
        bus_read(4'h8, d, v);
        checks++;
        if (d !== 32'h3FF || irq !== 1'b0) begin
            errors++;
            $display("FAIL irqen_rw got %h/%b want %h/0", d, irq, 32'h3FF);
        end
        raw_in[9] = 1'b1;
        tick(5);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early got %b want 0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b want 1", irq);
        end
        bus_read(4'h4, d, v);
        checks++;
        if (d !== 32'h200) begin
            errors++;
            $display("FAIL irq_event got %h want %h", d, 32'h200);
        end
        bus_write(4'h4, 32'h200);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_drop got %b want 0", irq);
        end
        bus_read(4'h4, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL irq_cleared got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        logic        v;
        raw_in[0] = 1'b1;
        tick(5);
        bus_write(4'h4, 32'h1);
        bus_read(4'h4, d, v);
        checks++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL set_wins got %h/%b want %h/1", d, irq, 32'h1);
        end
    endtask

    task automatic test_rd_wr();
        logic [31:0] d;
        logic        v;
        bus.bus_addr  = 4'h4;
        bus.bus_wdata = 32'h1;
        bus.bus_rd    = 1'b1;
        bus.bus_wr    = 1'b1;
        tick(1);
        bus.bus_rd = 1'b0;
        bus.bus_wr = 1'b0;
        checks++;
        if (bus.bus_rdata !== 32'h1 || bus.bus_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rdwr_event got %h/%b want %h/1",
                     bus.bus_rdata, bus.bus_rvalid, 32'h1);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rdwr_irq got %b want 0", irq);
        end
        bus.bus_addr  = 4'h8;
        bus.bus_wdata = 32'h5;
        bus.bus_rd    = 1'b1;
        bus.bus_wr    = 1'b1;
        tick(1);
        bus.bus_rd = 1'b0;
        bus.bus_wr = 1'b0;
        checks++;
        if (bus.bus_rdata !== 32'h3FF) begin
            errors++;
            $display("FAIL rdwr_irqen got %h want %h",
                     bus.bus_rdata, 32'h3FF);
        end
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'hC, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1) begin
            errors++;
            $display("FAIL unmapped got %h/%b want 0/1", d, v);
        end
        bus_read(4'h8, d, v);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL irqen_kept got %h want %h", d, 32'h5);
        end
        bus_read(4'h0, d, v);
        checks++;
        if (d !== 32'h209) begin
            errors++;
            $display("FAIL state_multi got %h want %h", d, 32'h209);
        end
        raw_in = '0;
        tick(8);
        bus_read(4'h0, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL state_fall got %h want %h", d, 32'h0);
        end
        bus_read(4'h4, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL fall_no_event got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        raw_in[5] = 1'b1;
        tick(3);
        reset_n = 1'b0;
        #2;
        checks++;
        if (irq !== 1'b0 || bus.bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got %b/%h want 0/0", irq, bus.bus_rdata);
        end
        reset_n = 1'b1;
        tick(5);
        bus_read(4'h0, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL requalify_early got %h want %h", d, 32'h0);
        end
        bus_read(4'h0, d, v);
        checks++;
        if (d !== 32'h20) begin
            errors++;
            $display("FAIL requalify got %h want %h", d, 32'h20);
        end
        bus_read(4'h4, d, v);
        checks++;
        if (d !== 32'h20) begin
            errors++;
            $display("FAIL requal_event got %h want %h", d, 32'h20);
        end
        bus_read(4'h8, d, v);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irqen got %h/%b want 0/0", d, irq);
        end
    endtask

    initial begin
        bus.bus_addr  = '0;
        bus.bus_rd    = 1'b0;
        bus.bus_wr    = 1'b0;
        bus.bus_wdata = '0;
        test_reset();
        test_rise();
        test_glitch();
        test_irq();
        test_set_wins();
        test_rd_wr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
